async_fifo_wr_ctrl: RTL and testbench
=====================================

Name: async_fifo_wr_ctrl

Overview:
- Write-side pointer/flag controller for the dual-clock FIFO.
- Second-generation block with these additions:
  - parametrised synchroniser depth
  - registered look-ahead full flag
  - registered Gray write pointer for export to the read domain
  - fill-level output and programmable almost-full
  - sticky overflow flag
- Sits in the wclk domain. Drives the RAM write port and exports wrptr_gray to the read-side controller.

Parameters:
- ADDR_W, 4: RAM address width; depth = 2^ADDR_W; legal range 2..12.
- SYNC_STAGES, 2: flops in the rdptr_gray synchroniser; legal range 2..4.
- AFULL_THRESH, 14: almost_full asserts when level >= this; legal range 1..2^ADDR_W.

Ports:
- wclk  in  1  write clock
- reset_L  in  1  asynchronous, active-low reset
- push  in  1  write request
- clr_ovf  in  1  clears overflow
- rdptr_gray  in  ADDR_W+1  read pointer (Gray) from the rclk domain, unsynchronised
- wr_en  out  1  RAM write enable
- waddr  out  ADDR_W  RAM write address
- wrptr_gray  out  ADDR_W+1  registered Gray write pointer, exported to the rclk domain
- full  out  1  FIFO full (registered)
- almost_full  out  1  level >= AFULL_THRESH (registered)
- wr_level  out  ADDR_W+1  words held, as seen by the write side (registered)
- overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (reset_L=0, asynchronous) clears:
  - wrptr_bin and wrptr_gray to 0
  - every synchroniser stage to 0
  - full, almost_full and overflow to 0
  - wr_level to 0
- On reset exit, every output holds 0 until the first accepted push.
- Reset mid-operation discards all pointer state. A pending write is not completed.
- Handshake:
  - wr_en = push & ~full, combinational.
  - waddr = wrptr_bin[ADDR_W-1:0], valid in the same cycle as wr_en.
  - Data is written at the wclk edge where wr_en=1.
- Pointer update:
  - bin_next = wrptr_bin + wr_en, modulo 2^(ADDR_W+1). Wrap-around drops the carry.
  - wrptr_gray <= bin_next ^ (bin_next >> 1). This output is a flop; no combinational path reaches it.
- Synchroniser:
  - rdptr_gray passes through SYNC_STAGES flops. rq is the last stage.
  - rd_bin = gray2bin(rq). All bits are converted, LSB included.
- Full (look-ahead, registered):
  - full <= (gray_next == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]}), where gray_next is the Gray code of bin_next.
  - full therefore asserts on the same edge that accepts the 2^ADDR_W-th outstanding word.
  - A push in the following cycle is refused.
- Full release: a rdptr_gray change reaches full after SYNC_STAGES+1 wclk edges. This is pessimistic and safe.
- Level:
  - wr_level <= bin_next - rd_bin, ADDR_W+1 bits, modulo arithmetic.
  - Range is 0..2^ADDR_W. The value 2^ADDR_W coincides with full=1.
- almost_full <= (bin_next - rd_bin) >= AFULL_THRESH. It is updated on the same edge as wr_level.
- Overflow:
  - Set when push & full.
  - Cleared when clr_ovf=1.
  - If set and clear occur in the same cycle, set wins.
  - A refused push never alters the pointers or the RAM.
- Simultaneous events:
  - A push and a read-pointer advance in the same cycle are resolved through the synchronised view only.
  - A push accepted while the read side frees a slot leaves full=1 until the freed slot propagates through the synchroniser.
- The input rdptr_gray may change at any time relative to wclk. Only the synchroniser's first stage samples it.

Decomposition:
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parametrised on width
  - parameter range checks, as elaboration-time asserts
- One sub-module: gray_ptr_sync, with parameters WIDTH and STAGES. It is a reset-to-0 multi-flop synchroniser and is reused by the read-side controller.
- All other logic stays inline.

Test Plan:
- Default parameters, rdptr_gray held at 0, push held at 1 for 20 cycles:
  - wr_en is high for exactly 16 cycles.
  - full rises on the edge that accepts the 16th word.
  - wr_level reads 16.
  - wrptr_gray reads 5'b11000 (binary 16).
  - overflow rises on cycle 17 and stays high after push drops.
  - clr_ovf=1 for one cycle clears it.
- From full (wrptr_bin=16), drive rdptr_gray to 5'b00001 (read pointer 1):
  - full deasserts exactly 3 wclk edges later (SYNC_STAGES=2).
  - wr_level reads 15, then one push makes full=1 again.
- Wrap-around: advance the read pointer so the writer cycles twice (32+ writes) with continuous push/pop:
  - wrptr_bin wraps from 31 to 0.
  - wrptr_gray is exercised through all 32 codes, with exactly one bit changing per accepted write.
  - full never asserts while wr_level < 16.
- almost_full with AFULL_THRESH=14:
  - Asserts on the edge where wr_level becomes 14.
  - Deasserts once the synchronised level drops to 13.
- Assert reset_L asynchronously mid-burst with wr_level=9 and overflow=1:
  - All outputs go to 0 immediately, without waiting for a wclk edge.
  - After release, the first push writes at waddr=0.
- Same-cycle clr_ovf=1 and push&full=1: overflow remains 1. Also run the full, release and wrap scenarios with ADDR_W=2 and SYNC_STAGES=3: full at 4 words, release after 4 edges.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary pointer helpers and parameter legality check
// shared by the dual-clock FIFO read- and write-side controllers.
`default_nettype none

package fifo_pkg;

  localparam int PTR_MAX_W = 13;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Narrower pointers are zero-extended into ptr_t and truncated afterwards.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic bit params_ok(input int addr_w, input int sync_stages,
                                   input int afull_thresh);
    return (addr_w >= 2) && (addr_w <= 12) &&
           (sync_stages >= 2) && (sync_stages <= 4) &&
           (afull_thresh >= 1) && (afull_thresh <= (1 << addr_w));
  endfunction

endpackage

`default_nettype wire

// File: rtl/async_fifo_wr_ctrl_if.sv
// async_fifo_wr_ctrl_if: write-side request/status bundle of the dual-clock FIFO.
`default_nettype none

interface async_fifo_wr_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              push;
  logic              clr_ovf;
  logic [ADDR_W:0]   rdptr_gray;
  logic              wr_en;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   wrptr_gray;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;

  modport master (
    output push, clr_ovf, rdptr_gray,
    input  wr_en, waddr, wrptr_gray, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  push, clr_ovf, rdptr_gray,
    output wr_en, waddr, wrptr_gray, full, almost_full, wr_level, overflow
  );
endinterface

`default_nettype wire

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync: reset-to-0 multi-flop synchroniser for a Gray-coded pointer
// crossing into the local clock domain.
`default_nettype none

module gray_ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             reset_L,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-side pointer/flag controller of the dual-clock FIFO
// (look-ahead full, almost-full, fill level, sticky overflow).
`default_nettype none

module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 14
) (
  input  wire logic          wclk,
  input  wire logic          reset_L,
  async_fifo_wr_ctrl_if.slave bus
);

  localparam int              PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AFULL_THRESH);

  generate
    if (!params_ok(ADDR_W, SYNC_STAGES, AFULL_THRESH)) begin : g_bad_params
      $error("async_fifo_wr_ctrl: parameter out of legal range");
    end
    if ($bits(bus.waddr) != ADDR_W) begin : g_bad_if_width
      $error("async_fifo_wr_ctrl: interface ADDR_W does not match");
    end
  endgenerate

  logic [PTR_W-1:0] r_wrptr_bin;
  logic [PTR_W-1:0] r_wrptr_gray;
  logic [PTR_W-1:0] r_wr_level;
  logic             r_full;
  logic             r_almost_full;
  logic             r_overflow;

  logic             w_wr_en;
  logic [PTR_W-1:0] w_bin_next;
  logic [PTR_W-1:0] w_gray_next;
  logic [PTR_W-1:0] w_rq;
  logic [PTR_W-1:0] w_rd_bin;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] w_full_match;

  gray_ptr_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk     (wclk),
    .reset_L (reset_L),
    .d       (bus.rdptr_gray),
    .q       (w_rq)
  );

  assign w_wr_en      = bus.push & ~r_full;
  assign w_bin_next   = r_wrptr_bin + PTR_W'(w_wr_en);
  assign w_gray_next  = PTR_W'(bin2gray(ptr_t'(w_bin_next)));
  assign w_rd_bin     = PTR_W'(gray2bin(ptr_t'(w_rq)));
  assign w_level_next = w_bin_next - w_rd_bin;
  // Writer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign w_full_match = {~w_rq[PTR_W-1:PTR_W-2], w_rq[PTR_W-3:0]};

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      r_wrptr_bin   <= '0;
      r_wrptr_gray  <= '0;
      r_wr_level    <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wrptr_bin   <= w_bin_next;
      r_wrptr_gray  <= w_gray_next;
      r_wr_level    <= w_level_next;
      r_full        <= (w_gray_next == w_full_match);
      r_almost_full <= (w_level_next >= AF_LVL);
      r_overflow    <= (bus.push & r_full) | (r_overflow & ~bus.clr_ovf);
    end
  end

  assign bus.wr_en       = w_wr_en;
  assign bus.waddr       = r_wrptr_bin[ADDR_W-1:0];
  assign bus.wrptr_gray  = r_wrptr_gray;
  assign bus.full        = r_full;
  assign bus.almost_full = r_almost_full;
  assign bus.wr_level    = r_wr_level;
  assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb_async_fifo_wr_ctrl: scoreboard bench for two write controllers side by side
// (ADDR_W=4/SYNC=2/AF=14 and ADDR_W=2/SYNC=3/AF=3).
`default_nettype none

module tb_async_fifo_wr_ctrl;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  async_fifo_wr_ctrl_if #(.ADDR_W(4)) bus0 ();
  async_fifo_wr_ctrl_if #(.ADDR_W(2)) bus1 ();

  async_fifo_wr_ctrl #(.ADDR_W(4), .SYNC_STAGES(2), .AFULL_THRESH(14)) dut0 (
    .wclk(clk), .reset_L(reset_L), .bus(bus0.slave));
  async_fifo_wr_ctrl #(.ADDR_W(2), .SYNC_STAGES(3), .AFULL_THRESH(3)) dut1 (
    .wclk(clk), .reset_L(reset_L), .bus(bus1.slave));

  typedef struct { int d; int acc; int gray; int full; int af; int lvl; int ovf; } exp_t;
  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;
  string onames[7] = '{"wr_en", "waddr", "wrptr_gray", "full", "almost_full", "wr_level", "overflow"};

  // reference state per DUT
  int m_wb[2], m_sq[2][4], m_full[2], m_ovf[2];
  int st_p[2], st_c[2], st_r[2];
  int n_acc[2];
  int pg[2];
  bit chk_wrap = 1'b0;
  bit [31:0] seen[2];

  function automatic int aw(int d); return (d == 0) ? 4 : 2; endfunction
  function automatic int ss(int d); return (d == 0) ? 2 : 3; endfunction
  function automatic int th(int d); return (d == 0) ? 14 : 3; endfunction

  function automatic logic [12:0] outv(int d, int sel);
    if (d == 0) begin
      case (sel)
        0: return 13'(bus0.wr_en);
        1: return 13'(bus0.waddr);
        2: return 13'(bus0.wrptr_gray);
        3: return 13'(bus0.full);
        4: return 13'(bus0.almost_full);
        5: return 13'(bus0.wr_level);
        default: return 13'(bus0.overflow);
      endcase
    end else begin
      case (sel)
        0: return 13'(bus1.wr_en);
        1: return 13'(bus1.waddr);
        2: return 13'(bus1.wrptr_gray);
        3: return 13'(bus1.full);
        4: return 13'(bus1.almost_full);
        5: return 13'(bus1.wr_level);
        default: return 13'(bus1.overflow);
      endcase
    end
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wb[d] = 0; m_full[d] = 0; m_ovf[d] = 0; pg[d] = 0;
      st_p[d] = 0; st_c[d] = 0; st_r[d] = 0;
      for (int i = 0; i < 4; i++) m_sq[d][i] = 0;
    end
  endtask

  // One wclk cycle: called at negedge, returns at the next negedge.
  task automatic step();
    exp_t e;
    logic [12:0] act;
    logic [12:0] ev[7];
    bus0.push = st_p[0][0]; bus0.clr_ovf = st_c[0][0];
    bus0.rdptr_gray = 5'(st_r[0] ^ (st_r[0] >> 1));
    bus1.push = st_p[1][0]; bus1.clr_ovf = st_c[1][0];
    bus1.rdptr_gray = 3'(st_r[1] ^ (st_r[1] >> 1));
    #1;
    for (int d = 0; d < 2; d++) begin
      int dep, mm, wbn, rq;
      dep = 1 << aw(d); mm = 2 * dep;
      e.d = d;
      e.acc = (st_p[d] != 0 && m_full[d] == 0) ? 1 : 0;
      act = outv(d, 0);
      n_vec++;
      if (act !== 13'(e.acc)) begin
        n_err++; $display("FAIL wr_en d%0d: got %0h expected %0h", d, act, e.acc);
      end
      if (e.acc != 0) begin
        act = outv(d, 1);
        n_vec++;
        if (act !== 13'(m_wb[d] % dep)) begin
          n_err++; $display("FAIL waddr d%0d: got %0h expected %0h", d, act, m_wb[d] % dep);
        end
      end
      if (act === 13'd1 && outv(d, 0) === 13'd1) n_acc[d]++;
      else if (outv(d, 0) === 13'd1) n_acc[d]++;
      wbn = (m_wb[d] + e.acc) % mm;
      rq = m_sq[d][ss(d)-1];
      e.lvl = (wbn - rq + mm) % mm;
      e.full = (e.lvl == dep) ? 1 : 0;
      e.af = (e.lvl >= th(d)) ? 1 : 0;
      e.ovf = (st_p[d] != 0 && m_full[d] != 0) ? 1 : ((st_c[d] != 0) ? 0 : m_ovf[d]);
      e.gray = wbn ^ (wbn >> 1);
      sbq.push_back(e);
      m_wb[d] = wbn; m_full[d] = e.full; m_ovf[d] = e.ovf;
      for (int i = ss(d) - 1; i > 0; i--) m_sq[d][i] = m_sq[d][i-1];
      m_sq[d][0] = st_r[d] % mm;
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      ev[2] = 13'(e.gray); ev[3] = 13'(e.full); ev[4] = 13'(e.af);
      ev[5] = 13'(e.lvl);  ev[6] = 13'(e.ovf);
      for (int s = 2; s < 7; s++) begin
        act = outv(e.d, s);
        n_vec++;
        if (act !== ev[s]) begin
          n_err++;
          $display("FAIL %s d%0d: got %0h expected %0h", onames[s], e.d, act, ev[s]);
        end
      end
      act = outv(e.d, 2);
      if (chk_wrap) begin
        n_vec++;
        if ($countones(act ^ 13'(pg[e.d])) != e.acc) begin
          n_err++; $display("FAIL gray_step d%0d: got %0h expected one-bit step from %0h", e.d, act, pg[e.d]);
        end
        n_vec++;
        if (outv(e.d, 3) === 13'd1 && outv(e.d, 5) < 13'(1 << aw(e.d))) begin
          n_err++; $display("FAIL full_early d%0d: got level %0d expected %0d", e.d, outv(e.d, 5), 1 << aw(e.d));
        end
        seen[e.d][act[4:0]] = 1'b1;
      end
      pg[e.d] = int'(act);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    model_reset();
    bus0.push = 1'b0; bus0.clr_ovf = 1'b0; bus0.rdptr_gray = '0;
    bus1.push = 1'b0; bus1.clr_ovf = 1'b0; bus1.rdptr_gray = '0;
    #1;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 7; s++) begin
        n_vec++;
        if (outv(d, s) !== 13'd0) begin
          n_err++; $display("FAIL reset_%s d%0d: got %0h expected 0", onames[s], d, outv(d, s));
        end
      end
    @(negedge clk);
    reset_L = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_fill_overflow();
    n_acc[0] = 0; n_acc[1] = 0;
    st_p[0] = 1; st_p[1] = 1;
    repeat (20) step();
    n_vec++;
    if (n_acc[0] != 16) begin n_err++; $display("FAIL wr_count d0: got %0d expected 16", n_acc[0]); end
    n_vec++;
    if (n_acc[1] != 4) begin n_err++; $display("FAIL wr_count d1: got %0d expected 4", n_acc[1]); end
    n_vec++;
    if (bus0.wrptr_gray !== 5'b11000) begin n_err++; $display("FAIL gray_full d0: got %b expected 11000", bus0.wrptr_gray); end
    n_vec++;
    if (bus0.wr_level !== 5'd16) begin n_err++; $display("FAIL level_full d0: got %0d expected 16", bus0.wr_level); end
    st_p[0] = 0; st_p[1] = 0;
    step();
    n_vec++;
    if (bus0.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky d0: got %b expected 1", bus0.overflow); end
    st_c[0] = 1; st_c[1] = 1;
    step();
    st_c[0] = 0; st_c[1] = 0;
    n_vec++;
    if (bus0.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear d0: got %b expected 0", bus0.overflow); end
  endtask

  task automatic test_same_cycle_clr();
    st_p[0] = 1; st_p[1] = 1; st_c[0] = 1; st_c[1] = 1;
    step();
    st_p[0] = 0; st_p[1] = 0; st_c[0] = 0; st_c[1] = 0;
    n_vec++;
    if (bus0.overflow !== 1'b1 || bus1.overflow !== 1'b1) begin
      n_err++; $display("FAIL ovf_set_wins: got %b%b expected 11", bus0.overflow, bus1.overflow);
    end
  endtask

  task automatic test_release();
    int rel[2];
    rel[0] = 0; rel[1] = 0;
    st_r[0] = 1; st_r[1] = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (rel[0] == 0 && bus0.full === 1'b0) rel[0] = k;
      if (rel[1] == 0 && bus1.full === 1'b0) rel[1] = k;
    end
    n_vec++;
    if (rel[0] != 3) begin n_err++; $display("FAIL release_edges d0: got %0d expected 3", rel[0]); end
    n_vec++;
    if (rel[1] != 4) begin n_err++; $display("FAIL release_edges d1: got %0d expected 4", rel[1]); end
    n_vec++;
    if (bus0.wr_level !== 5'd15) begin n_err++; $display("FAIL level_release d0: got %0d expected 15", bus0.wr_level); end
    st_p[0] = 1; st_p[1] = 1;
    step();
    st_p[0] = 0; st_p[1] = 0;
    n_vec++;
    if (bus0.full !== 1'b1 || bus1.full !== 1'b1) begin
      n_err++; $display("FAIL refill: got full %b%b expected 11", bus0.full, bus1.full);
    end
  endtask

  task automatic test_wrap();
    seen[0] = '0; seen[1] = '0;
    chk_wrap = 1'b1;
    st_p[0] = 1; st_p[1] = 1;
    repeat (100) begin
      for (int d = 0; d < 2; d++) begin
        int mm;
        mm = 2 << aw(d);
        if ((m_wb[d] - st_r[d] + mm) % mm > 0) st_r[d] = (st_r[d] + 1) % mm;
      end
      step();
    end
    chk_wrap = 1'b0;
    st_p[0] = 0; st_p[1] = 0;
    n_vec++;
    if (seen[0] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL gray_codes d0: got %h expected ffffffff", seen[0]); end
    n_vec++;
    if (seen[1][7:0] !== 8'hFF) begin n_err++; $display("FAIL gray_codes d1: got %h expected ff", seen[1][7:0]); end
  endtask

  task automatic test_almost_full();
    int rise[2], fall[2], paf[2];
    rise = '{-1, -1}; fall = '{-1, -1};
    st_r[0] = m_wb[0]; st_r[1] = m_wb[1];
    repeat (8) step();
    paf[0] = int'(bus0.almost_full); paf[1] = int'(bus1.almost_full);
    st_p[0] = 1; st_p[1] = 1;
    repeat (20) begin
      step();
      for (int d = 0; d < 2; d++) begin
        if (rise[d] < 0 && paf[d] == 0 && outv(d, 4) === 13'd1) rise[d] = int'(outv(d, 5));
        paf[d] = int'(outv(d, 4));
      end
    end
    st_p[0] = 0; st_p[1] = 0;
    repeat (25) begin
      for (int d = 0; d < 2; d++) begin
        int mm;
        mm = 2 << aw(d);
        if ((m_wb[d] - st_r[d] + mm) % mm > 0) st_r[d] = (st_r[d] + 1) % mm;
      end
      step();
      for (int d = 0; d < 2; d++) begin
        if (fall[d] < 0 && paf[d] == 1 && outv(d, 4) === 13'd0) fall[d] = int'(outv(d, 5));
        paf[d] = int'(outv(d, 4));
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rise[d] != th(d)) begin n_err++; $display("FAIL af_rise d%0d: got level %0d expected %0d", d, rise[d], th(d)); end
      n_vec++;
      if (fall[d] != th(d) - 1) begin n_err++; $display("FAIL af_fall d%0d: got level %0d expected %0d", d, fall[d], th(d) - 1); end
    end
  endtask

  task automatic test_async_reset();
    st_p[0] = 1; st_p[1] = 1;
    repeat (20) step();
    st_p[0] = 0; st_p[1] = 0;
    st_r[0] = (m_wb[0] - 9 + 32) % 32;
    st_r[1] = (m_wb[1] - 1 + 8) % 8;
    repeat (5) step();
    n_vec++;
    if (bus0.wr_level !== 5'd9 || bus0.overflow !== 1'b1) begin
      n_err++; $display("FAIL pre_reset d0: got level %0d ovf %b expected 9 1", bus0.wr_level, bus0.overflow);
    end
    #2;
    reset_L = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 7; s++) begin
        n_vec++;
        if (outv(d, s) !== 13'd0) begin
          n_err++; $display("FAIL async_reset_%s d%0d: got %0h expected 0", onames[s], d, outv(d, s));
        end
      end
    model_reset();
    bus0.rdptr_gray = '0; bus1.rdptr_gray = '0;
    @(negedge clk);
    reset_L = 1'b1;
    st_p[0] = 1; st_p[1] = 1;
    bus0.push = 1'b1; bus1.push = 1'b1;
    #1;
    n_vec++;
    if (bus0.wr_en !== 1'b1 || bus0.waddr !== 4'd0) begin
      n_err++; $display("FAIL first_waddr d0: got en %b addr %0d expected 1 0", bus0.wr_en, bus0.waddr);
    end
    #1;
    step();
    st_p[0] = 0; st_p[1] = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_same_cycle_clr();
    test_release();
    test_wrap();
    test_almost_full();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
